// File: rtl/ps2_rx.sv
// PS/2 host receiver: input synchroniser + glitch filter, 11-bit frame FSM, show-ahead byte FIFO.
// Define PS2_RX_PARITY_CHECK_EN to drop bytes with a bad parity bit and pulse parity_err.
module ps2_rx #(
    parameter int FIFO_BITS = 3,
    parameter int FILTER    = 4,
    parameter int TIMEOUT   = 16384
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_read,
    output logic [FIFO_BITS:0]   fifo_level,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overflow
);
    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int LW    = FIFO_BITS + 1;
    localparam int FW    = $clog2(FILTER + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic fclk_q, fclk_d, fclk_prev_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic fall;

    state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic frame_err_q, frame_err_d;
    logic byte_done;
`ifdef PS2_RX_PARITY_CHECK_EN
    logic par_ok_q, par_ok_d;
    logic parity_err_q, parity_err_d;
`endif

    logic [7:0] mem_q [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic overflow_q, overflow_d;
    logic pop, push, full;

    // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
            fclk_q      <= fclk_d;
            fclk_prev_q <= fclk_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latches are inferred.
    always_comb begin
        fclk_d     = fclk_q;
        filt_cnt_d = '0;
        if (clk_sync_q != fclk_q) begin
            if (filt_cnt_q == FW'(FILTER - 1)) fclk_d = clk_sync_q;
            else filt_cnt_d = filt_cnt_q + FW'(1);
        end
    end

    assign fall = fclk_prev_q & ~fclk_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        tmo_d       = '0;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
        par_ok_d     = par_ok_q;
        parity_err_d = 1'b0;
`endif
        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_sync_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                        par_d     = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shreg_d   = {data_sync_q, shreg_q[7:1]};
                    par_d     = par_q ^ data_sync_q;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
                    par_ok_d = (data_sync_q == par_q);
`endif
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!data_sync_q) frame_err_d = 1'b1;
`ifdef PS2_RX_PARITY_CHECK_EN
                    else if (!par_ok_q) parity_err_d = 1'b1;
`endif
                    else byte_done = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // A stalled device leaves a partial frame behind; abandon it.
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d     = S_IDLE;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b1;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            par_ok_q     <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_ok_q     <= par_ok_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    always_comb begin
        pop        = rx_valid & rx_read;
        full       = (level_q == LW'(DEPTH));
        push       = byte_done & (~full | pop);
        overflow_d = byte_done & full & ~pop;
        wr_ptr_d   = push ? wr_ptr_q + FIFO_BITS'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + FIFO_BITS'(1) : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop) level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: FIFO storage is not reset; rx_valid gates it so stale contents are never visible.
    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q] <= shreg_q;
    end

    assign rx_valid   = (level_q != '0);
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_level = level_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule
